// File: rtl/soc_mem_arbiter_if.sv
// soc_mem_arbiter_if: both master request ports plus the shared memory port of the arbiter
interface soc_mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              m0_req, m1_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [3:0]        m0_wmask, m1_wmask;
  logic [31:0]       m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [31:0]       m_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rstrb;
  logic [31:0]       mem_rdata;
  logic              mem_rbusy;
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wmask, m1_wmask, m0_wdata, m1_wdata,
    input  mem_rdata, mem_rbusy,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_rdata,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wmask, m1_wmask, m0_wdata, m1_wdata,
    output mem_rdata, mem_rbusy,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_rdata,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );
endinterface

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: round-robin two-master arbiter for a shared RAM/IO port with a read wait state
module soc_mem_arbiter #(parameter int ADDR_W = 32) (
  input logic              clk,
  input logic              reset,
  soc_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RWAIT} state_t;
  state_t            state, state_n;
  logic              last, owner, g0, g1, sel, rd, rvalid;
  logic [3:0]        wmask;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata_q;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    g1             = state == IDLE && !reset && bus.m1_req && (!bus.m0_req || !last);
    g0             = state == IDLE && !reset && bus.m0_req && !g1;
    sel            = state == RWAIT ? owner : g1;
    wmask          = sel ? bus.m1_wmask : bus.m0_wmask;
    rd             = (g0 || g1) && wmask == 4'b0000;
    rvalid         = state == RWAIT && !reset && !bus.mem_rbusy;
    state_n        = rd ? RWAIT : rvalid ? IDLE : state;
    bus.m0_gnt     = g0;
    bus.m1_gnt     = g1;
    bus.m0_rvalid  = rvalid && !owner;
    bus.m1_rvalid  = rvalid && owner;
    bus.m_rdata    = rvalid ? bus.mem_rdata : rdata_q;
    bus.mem_addr   = state == RWAIT ? raddr : sel ? bus.m1_addr : bus.m0_addr;
    bus.mem_wdata  = sel ? bus.m1_wdata : bus.m0_wdata;
    bus.mem_wmask  = (g0 || g1) ? wmask : 4'b0000;
    bus.mem_rstrb  = rd;
  end
  always_ff @(posedge clk)
    if (reset) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      raddr   <= '0;
      rdata_q <= '0;
    end else begin
      if (g0 || g1) last <= g1;
      if (rd) begin
        owner <= g1;
        raddr <= g1 ? bus.m1_addr : bus.m0_addr;
      end
      if (rvalid) rdata_q <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: randomized and directed check of soc_mem_arbiter against a transaction-level model
module tb_soc_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  soc_mem_arbiter_if bus();
  soc_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [3:0]  wm    [2];
  logic [31:0] wd    [2];
  logic        rbusy;
  logic [31:0] rdata;
  assign bus.m0_req    = req[0];
  assign bus.m1_req    = req[1];
  assign bus.m0_addr   = addr[0];
  assign bus.m1_addr   = addr[1];
  assign bus.m0_wmask  = wm[0];
  assign bus.m1_wmask  = wm[1];
  assign bus.m0_wdata  = wd[0];
  assign bus.m1_wdata  = wd[1];
  assign bus.mem_rbusy = rbusy;
  assign bus.mem_rdata = rdata;
  int          n_cmp = 0, n_err = 0;
  int          last_g = 1, pend = -1, won = -1;
  logic [31:0] pend_addr = '0, held = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_m(int i, logic r, logic [31:0] a, logic [3:0] m, logic [31:0] d);
    req[i] = r; addr[i] = a; wm[i] = m; wd[i] = d;
  endtask
  task automatic new_req(int i);
    set_m(i, $urandom_range(0, 2) != 0, $urandom,
          $urandom_range(0, 1) != 0 ? 4'b0000 : 4'($urandom), $urandom);
  endtask
  task automatic tick();
    int w;
    logic [1:0] egnt, evalid;
    logic [3:0] ewm;
    logic erstrb;
    logic [31:0] eaddr, erd;
    @(negedge clk);
    w = -1; egnt = '0; evalid = '0; ewm = '0; erstrb = 1'b0; eaddr = addr[0]; erd = held;
    if (reset) begin
      last_g = 1; pend = -1; held = '0;
    end else begin
      if (pend >= 0) begin
        eaddr = pend_addr;
        if (!rbusy) begin
          evalid[pend] = 1'b1;
          erd = rdata;
          held = rdata;
          pend = -1;
        end
      end else begin
        if (req[0] && req[1]) w = 1 - last_g;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        if (w >= 0) begin
          egnt[w] = 1'b1;
          eaddr = addr[w];
          last_g = w;
          if (wm[w] != 4'b0000) ewm = wm[w];
          else begin
            erstrb = 1'b1;
            pend = w;
            pend_addr = addr[w];
          end
        end
        chk("mem_wdata", bus.mem_wdata, wd[w == 1 ? 1 : 0]);
      end
      chk("mem_addr", bus.mem_addr, eaddr);
      chk("m_rdata", bus.m_rdata, erd);
    end
    chk("gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, {30'b0, egnt});
    chk("rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, {30'b0, evalid});
    chk("mem_wmask", {28'b0, bus.mem_wmask}, {28'b0, ewm});
    chk("mem_rstrb", {31'b0, bus.mem_rstrb}, {31'b0, erstrb});
    won = w;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; rbusy = 1'b0; rdata = '0;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_rdata", bus.m_rdata, 32'h0);
    set_m(0, 1, 32'h10, 4'b0000, 0);
    rdata = 32'hDEADBEEF;
    tick();
    req[0] = 1'b0;
    tick();
    chk("rdata_hold", bus.m_rdata, 32'hDEADBEEF);
    set_m(0, 1, 32'h100, 4'b1111, 32'h11111111);
    set_m(1, 1, 32'h200, 4'b1111, 32'h22222222);
    repeat (6) begin
      tick();
      wd[0]++;
      wd[1]++;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    set_m(1, 1, 32'h300, 4'b0000, 0);
    rbusy = 1'b1;
    tick();
    req[1] = 1'b0;
    set_m(0, 1, 32'h500, 4'b0011, 32'h55);
    repeat (3) tick();
    rbusy = 1'b0; rdata = 32'hCAFEF00D;
    tick();
    tick();
    req[0] = 1'b0;
    set_m(1, 1, 32'h400003FC, 4'b0100, 32'h00AB0000);
    tick();
    req[1] = 1'b0;
    tick();
    set_m(0, 1, 32'h20, 4'b0000, 0);
    rbusy = 1'b1;
    tick();
    req[0] = 1'b0;
    tick();
    reset = 1'b1; rbusy = 1'b0; rdata = 32'h12345678;
    tick();
    reset = 1'b0;
    set_m(0, 1, 32'h30, 4'b0000, 0);
    set_m(1, 1, 32'h40, 4'b0000, 0);
    tick();
    chk("tie_after_reset", won, 0);
    req[0] = 1'b0;
    tick();
    tick();
    new_req(0);
    new_req(1);
    repeat (3000) begin
      reset = $urandom_range(0, 99) == 0;
      rbusy = $urandom_range(0, 2) == 0;
      rdata = $urandom;
      tick();
      for (int i = 0; i < 2; i++)
        if (!req[i] || won == i) new_req(i);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
